// File: rtl/guess_game_pkg.sv
// Shared types and constants for the guess_game_core number-guessing engine.
// Holds the FSM state enum, the tries-counter width and the LFSR tap table.
package guess_game_pkg;

   localparam int unsigned TRY_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAY,
      ST_WIN,
      ST_LOSE
   } state_t;

   // Right-shifting Galois masks for primitive polynomials; bit (n-1) is tap x^n.
   function automatic logic [15:0] lfsr_taps(input int unsigned width);
      case (width)
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0E08;
         13:      return 16'h1C80;
         14:      return 16'h3802;
         15:      return 16'h6000;
         16:      return 16'hB400;
         default: return 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/guess_game_core_if.sv
// Player-side bundle of guess_game_core: round control and guess inputs, status outputs.
// With GUESS_BEST_SCORE_EN defined the bundle also carries the best-score output.
interface guess_game_core_if
   import guess_game_pkg::*;
#(
   parameter int unsigned WIDTH = 8
);

   logic             start;
   logic             set_secret;
   logic [WIDTH-1:0] guess;
   logic             guess_valid;

   logic             busy;
   logic             higher;
   logic             lower;
   logic             win;
   logic             lose;
   logic [TRY_W-1:0] tries;
   logic [WIDTH-1:0] secret_out;
`ifdef GUESS_BEST_SCORE_EN
   logic [TRY_W-1:0] best;
`endif

   modport master (
      output start, set_secret, guess, guess_valid,
`ifdef GUESS_BEST_SCORE_EN
      input  best,
`endif
      input  busy, higher, lower, win, lose, tries, secret_out
   );

   modport slave (
      input  start, set_secret, guess, guess_valid,
`ifdef GUESS_BEST_SCORE_EN
      output best,
`endif
      output busy, higher, lower, win, lose, tries, secret_out
   );

endinterface

// File: rtl/guess_lfsr.sv
// Free-running Galois LFSR, WIDTH bits, stepping every cycle; supplies random secrets.
module guess_lfsr
   import guess_game_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEED  = 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] MASK   = WIDTH'(lfsr_taps(WIDTH));
   localparam logic [WIDTH-1:0] SEED_T = WIDTH'(SEED);
   // A seed that truncates to zero would lock the register; fall back to 1.
   localparam logic [WIDTH-1:0] START  = (SEED_T == '0) ? WIDTH'(1) : SEED_T;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= START;
      end else begin
         value <= (value >> 1) ^ (value[0] ? MASK : '0);
      end
   end

endmodule

// File: rtl/guess_game_core.sv
// Number-guessing engine: hidden secret vs. player guesses, hints, tries, win/lose.
// Optional macro GUESS_BEST_SCORE_EN adds a best-score (fewest winning tries) register.
module guess_game_core
   import guess_game_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_TRIES = 7,
   parameter int unsigned SEED      = 1
) (
   input  logic             clk,
   input  logic             rst,
   guess_game_core_if.slave bus
);

   localparam logic [TRY_W:0] LOSE_AT = (TRY_W + 1)'(MAX_TRIES);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] secret_q, secret_d;
   logic [WIDTH-1:0] manual_q, manual_d;
   logic             flag_q, flag_d;
   logic [TRY_W-1:0] tries_q, tries_d;
   logic             higher_q, higher_d;
   logic             lower_q, lower_d;
   logic             win_q, win_d;
   logic             lose_q, lose_d;
`ifdef GUESS_BEST_SCORE_EN
   logic [TRY_W-1:0] best_q, best_d;
`endif

   logic [WIDTH-1:0] lfsr_value;
   logic             eff_flag;
   logic [WIDTH-1:0] eff_manual;
   logic [TRY_W-1:0] tries_inc;

   guess_lfsr #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (lfsr_value)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         secret_q <= '0;
         manual_q <= '0;
         flag_q   <= 1'b0;
         tries_q  <= '0;
         higher_q <= 1'b0;
         lower_q  <= 1'b0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
`ifdef GUESS_BEST_SCORE_EN
         best_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         secret_q <= secret_d;
         manual_q <= manual_d;
         flag_q   <= flag_d;
         tries_q  <= tries_d;
         higher_q <= higher_d;
         lower_q  <= lower_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
`ifdef GUESS_BEST_SCORE_EN
         best_q   <= best_d;
`endif
      end
   end

   assign tries_inc = (tries_q == '1) ? tries_q : tries_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      secret_d   = secret_q;
      manual_d   = manual_q;
      flag_d     = flag_q;
      tries_d    = tries_q;
      higher_d   = higher_q;
      lower_d    = lower_q;
      win_d      = win_q;
      lose_d     = lose_q;
`ifdef GUESS_BEST_SCORE_EN
      best_d     = best_q;
`endif
      eff_flag   = flag_q;
      eff_manual = manual_q;

      unique case (state_q)
         ST_PLAY: begin
            if (bus.guess_valid) begin
               tries_d = tries_inc;
               if (bus.guess == secret_q) begin
                  win_d    = 1'b1;
                  higher_d = 1'b0;
                  lower_d  = 1'b0;
                  state_d  = ST_WIN;
`ifdef GUESS_BEST_SCORE_EN
                  if (best_q == '0 || tries_inc < best_q) begin
                     best_d = tries_inc;
                  end
`endif
               end else begin
                  higher_d = (bus.guess < secret_q);
                  lower_d  = (bus.guess > secret_q);
                  if (({1'b0, tries_q} + 1'b1) == LOSE_AT) begin
                     lose_d  = 1'b1;
                     state_d = ST_LOSE;
                  end
               end
            end
         end
         ST_IDLE, ST_WIN, ST_LOSE: begin
            // set_secret is folded in first so a same-cycle start sees the new value.
            if (state_q == ST_IDLE && bus.set_secret && bus.guess != '0) begin
               eff_flag   = 1'b1;
               eff_manual = bus.guess;
            end
            flag_d   = eff_flag;
            manual_d = eff_manual;
            if (bus.start) begin
               secret_d = eff_flag ? eff_manual : lfsr_value;
               flag_d   = 1'b0;
               tries_d  = '0;
               higher_d = 1'b0;
               lower_d  = 1'b0;
               win_d    = 1'b0;
               lose_d   = 1'b0;
               state_d  = ST_PLAY;
            end
         end
      endcase
   end

   assign bus.busy       = (state_q == ST_PLAY);
   assign bus.higher     = higher_q;
   assign bus.lower      = lower_q;
   assign bus.win        = win_q;
   assign bus.lose       = lose_q;
   assign bus.tries      = tries_q;
   assign bus.secret_out = (state_q == ST_WIN || state_q == ST_LOSE) ? secret_q : '0;
`ifdef GUESS_BEST_SCORE_EN
   assign bus.best       = best_q;
`endif

endmodule

// File: doc/guess_game_core.md
Name: guess_game_core

Overview:
- Parametrised number-guessing engine, the next generation of the game logic behind the team's Tiny Tapeout top (tt_um_julke_gussinatorn).
- Holds a hidden secret from a free-running LFSR and compares player guesses against it.
- Reports higher/lower/correct, counts attempts, and ends the round on a win or when attempts run out.
- Sits between the pad-level top (ui_in/uio_in decode) and the display/LED drivers on uo_out.

Parameters:
- WIDTH, 8: bit width of secret and guess (legal range 4..16).
- MAX_TRIES, 7: attempts allowed per round (1..255).
- SEED, 1: LFSR reset value; nonzero, truncated to WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  pulse: begin a round (honoured in IDLE, WIN, LOSE).
- set_secret  in  1  pulse: in IDLE, latch guess as the next round's secret.
- guess  in  WIDTH  player guess / secret value.
- guess_valid  in  1  one-cycle strobe: guess presented.
- busy  out  1  round in progress (PLAY).
- higher  out  1  last guess below secret.
- lower  out  1  last guess above secret.
- win  out  1  round won (sticky until next start).
- lose  out  1  attempts exhausted (sticky until next start).
- tries  out  8  attempts used in the current/last round.
- secret_out  out  WIDTH  secret, shown only in WIN/LOSE, else 0.

Behaviour:
- Reset: state=IDLE, LFSR=SEED, all outputs 0, manual-secret flag cleared.
- LFSR: Galois, WIDTH bits, maximal-length taps from the package; steps every cycle in every state, never 0.
- FSM states: IDLE, PLAY, WIN, LOSE.
- IDLE/WIN/LOSE + start -> PLAY next cycle:
  - secret = manual value if the flag is set, else current LFSR value; flag then cleared.
  - tries=0; higher/lower/win/lose cleared; busy=1.
- IDLE + set_secret:
  - guess==0: ignored.
  - guess!=0: stored, flag set.
  - Same cycle as start: set_secret is applied first, so start uses the new value.
- PLAY + guess_valid:
  - Registered, 1-cycle latency; tries increments (saturating at 255).
  - guess<secret: higher=1, lower=0.
  - guess>secret: lower=1, higher=0.
  - guess==secret: win=1, higher=lower=0, go to WIN.
  - Mismatch with tries+1==MAX_TRIES: lose=1, go to LOSE; higher/lower still show the final hint.
- PLAY ignores start and set_secret. guess_valid outside PLAY is ignored.
- Comparison is unsigned, full WIDTH. A guess of 0 is legal and always gives higher.
- Reset mid-round: returns immediately to IDLE and discards the round.

Optional Feature:
- Macro: GUESS_BEST_SCORE_EN.
- Defined:
  - Adds output best[7:0], reset 0 (meaning "none").
  - On entry to WIN, best=tries if best==0 or tries<best.
  - Unaffected by LOSE; cleared only by rst.
- Undefined: no best port, no register.

Decomposition:
- Package guess_game_pkg:
  - state enum.
  - Function returning the LFSR tap mask for WIDTH 4..16.
  - Constant TRY_W=8.
- Sub-module guess_lfsr (WIDTH, SEED): free-running Galois LFSR, output value.

Test Plan:
- Manual win: rst; set_secret guess=8'h5A; start; guesses 8'h10, 8'hF0, 8'h5A -> higher, then lower, then win=1; tries=3; secret_out=8'h5A; busy=0.
- Loss: MAX_TRIES=3; secret 8'h20; guesses 1, 2, 3 -> lose=1 after third; tries=3; higher=1; further guess_valid leaves tries=3.
- Ignored inputs: set_secret with guess 0 -> LFSR secret used (secret_out nonzero at end); start during PLAY -> tries unchanged; guess_valid in IDLE -> tries=0.
- LFSR: SEED=1, WIDTH=4 -> period 15, never 0; start after N cycles -> secret matches reference model.
- Reset mid-round: after two guesses assert rst -> all outputs 0, IDLE; next start begins with tries=0.
- GUESS_BEST_SCORE_EN: wins in 4 then 2 then 5 tries -> best=4, 2, 2; a loss leaves best=2.
